// File: rtl/max_pool_pkg.sv
// rtl/max_pool_pkg.sv - shared constants and state encoding for the max pooling block
package max_pool_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 8;
  localparam int WIN_W_DEF  = 16;

  localparam logic [DATA_W_DEF-1:0] SMIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/max_pool_cmp.sv
// rtl/max_pool_cmp.sv - combinational signed two-input maximum
module max_pool_cmp #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_max
);

  // Ties resolve to i_a; equal values are indistinguishable so the choice is moot.
  assign o_max = ($signed(i_a) >= $signed(i_b)) ? i_a : i_b;

endmodule

// File: rtl/max_pool.sv
// rtl/max_pool.sv - windowed signed max pooling over a stalled sample stream
module max_pool
  import max_pool_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WIN_W  = WIN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              running,
  input  logic [DATA_W-1:0] in0,
  input  logic [CNT_W-1:0]  windowSize,
  input  logic [WIN_W-1:0]  numWindows,
  output logic [DATA_W-1:0] out0,
  output logic              out1,
  output logic              done
);

  state_t            r_state;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_out0;
  logic              r_out1;
  logic [CNT_W-1:0]  r_smp_cnt;
  logic [CNT_W-1:0]  r_win_size;
  logic [WIN_W-1:0]  r_win_cnt;
  logic [WIN_W-1:0]  r_num_win;

  logic [DATA_W-1:0] w_max;
  logic [DATA_W-1:0] w_next;
  logic [CNT_W-1:0]  w_last_idx;
  logic              w_last_smp;
  logic              w_last_win;

  max_pool_cmp #(.DATA_W(DATA_W)) u_cmp (
    .i_a   (r_acc),
    .i_b   (in0),
    .o_max (w_max)
  );

  // A zero window size behaves as a one-sample window.
  assign w_last_idx = (r_win_size == '0) ? '0 : r_win_size - CNT_W'(1);
  assign w_last_smp = (r_smp_cnt == w_last_idx);
  assign w_last_win = (r_win_cnt == r_num_win - WIN_W'(1));
  assign w_next     = (r_smp_cnt == '0) ? in0 : w_max;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_acc      <= '0;
      r_out0     <= '0;
      r_out1     <= 1'b0;
      r_smp_cnt  <= '0;
      r_win_size <= '0;
      r_win_cnt  <= '0;
      r_num_win  <= '0;
    end else begin
      r_out1 <= 1'b0;
      if (run) begin
        r_win_size <= windowSize;
        r_num_win  <= numWindows;
        r_smp_cnt  <= '0;
        r_win_cnt  <= '0;
        r_state    <= (numWindows == '0) ? ST_DONE : ST_ACCUM;
      end else if (r_state == ST_ACCUM && running) begin
        r_acc <= w_next;
        if (w_last_smp) begin
          r_out0    <= w_next;
          r_out1    <= 1'b1;
          r_smp_cnt <= '0;
          r_win_cnt <= r_win_cnt + WIN_W'(1);
          if (w_last_win) begin
            r_state <= ST_DONE;
          end
        end else begin
          r_smp_cnt <= r_smp_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign out0 = r_out0;
  assign out1 = r_out1;
  assign done = (r_state != ST_ACCUM);

endmodule
